// File: rtl/pu_types_pkg.sv
// Shared processor-unit types for the SPR access controller.
// Holds the controller state and requester encodings plus the Word type.
package pu_types;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } spr_ctrl_state_e;

   typedef enum logic {
      REQ_PIPE = 1'b0,
      REQ_DBG  = 1'b1
   } spr_requester_e;

endpackage

// File: rtl/spr_arbiter.sv
// Two-way round-robin arbiter between pipeline and debug SPR requesters.
// With SPR_DEBUG_PORT_EN undefined the pipeline is always granted.
module spr_arbiter
   import pu_types::*;
(
   input  logic clk,
   input  logic reset,
   input  logic pipe_req,
   input  logic dbg_req,
   input  logic accept,
   output logic valid,
   output logic grant
);

`ifdef SPR_DEBUG_PORT_EN
   logic last_grant_q;
   logic last_grant_d;

   always_comb begin
      valid = pipe_req | dbg_req;
      grant = REQ_PIPE;
      if (pipe_req && dbg_req) begin
         grant = (last_grant_q == REQ_DBG) ? REQ_PIPE : REQ_DBG;
      end else if (dbg_req) begin
         grant = REQ_DBG;
      end
      last_grant_d = last_grant_q;
      if (accept && valid) begin
         last_grant_d = grant;
      end
   end

   // Reset to debug so that the pipeline wins the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= REQ_DBG;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`else
   logic unused_arb;

   assign valid      = pipe_req;
   assign grant      = REQ_PIPE;
   assign unused_arb = ^{clk, reset, dbg_req, accept};
`endif

endmodule

// File: rtl/spr_access_ctrl.sv
// SPR access controller: arbitrates pipeline/debug requests onto the SPR bus.
// Debug port and round-robin arbitration are enabled by SPR_DEBUG_PORT_EN.
module spr_access_ctrl
   import pu_types::*;
#(
   parameter int TIMEOUT = 16,
   parameter int SEL_W   = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pipe_req,
   input  logic             pipe_we,
   input  logic [SEL_W-1:0] pipe_sel,
   input  logic [31:0]      pipe_wdata,
   output logic             pipe_done,
   output logic             pipe_stall,
   output logic [31:0]      pipe_rdata,
   input  logic             dbg_req,
   input  logic             dbg_we,
   input  logic [SEL_W-1:0] dbg_sel,
   input  logic [31:0]      dbg_wdata,
   output logic             dbg_done,
   output logic [31:0]      dbg_rdata,
   output logic             bus_req,
   output logic             bus_we,
   output logic [SEL_W-1:0] bus_sel,
   output logic [31:0]      bus_wdata,
   input  logic             bus_ack,
   input  logic [31:0]      bus_rdata,
   output logic             err,
   input  logic             err_clr
);

   localparam logic [1:0] IDLE = ST_IDLE;
   localparam logic [1:0] BUS  = ST_BUS;
   localparam logic [1:0] RESP = ST_RESP;
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   logic [1:0]       state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             we_q, we_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   word_t            wdata_q, wdata_d;
   logic             who_q, who_d;
   word_t            res_q, res_d;
   logic             pdone_q, pdone_d;
   logic             ddone_q, ddone_d;
   word_t            prdata_q, prdata_d;
   word_t            drdata_q, drdata_d;
   logic             err_q, err_d;

   logic             arb_pipe;
   logic             arb_dbg;
   logic             arb_valid;
   logic             arb_grant;

   // A requester sees done in the cycle it may still hold req; mask it
   // so the completed access is not issued a second time.
   assign arb_pipe = pipe_req & ~pdone_q;
`ifdef SPR_DEBUG_PORT_EN
   assign arb_dbg  = dbg_req & ~ddone_q;
`else
   logic unused_dbg;
   assign arb_dbg    = 1'b0;
   assign unused_dbg = dbg_req;
`endif

   spr_arbiter u_arb (
      .clk      (clk),
      .reset    (reset),
      .pipe_req (arb_pipe),
      .dbg_req  (arb_dbg),
      .accept   (state_q == IDLE),
      .valid    (arb_valid),
      .grant    (arb_grant)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      sel_d    = sel_q;
      wdata_d  = wdata_q;
      who_d    = who_q;
      res_d    = res_q;
      pdone_d  = 1'b0;
      ddone_d  = 1'b0;
      prdata_d = prdata_q;
      drdata_d = drdata_q;
      err_d    = err_q & ~err_clr;
      unique case (state_q)
         IDLE: begin
            if (arb_valid) begin
               who_d   = arb_grant;
               we_d    = (arb_grant == REQ_DBG) ? dbg_we : pipe_we;
               sel_d   = (arb_grant == REQ_DBG) ? dbg_sel : pipe_sel;
               wdata_d = (arb_grant == REQ_DBG) ? dbg_wdata : pipe_wdata;
               cnt_d   = 8'd0;
               state_d = BUS;
            end
         end
         BUS: begin
            if (bus_ack) begin
               res_d   = we_q ? 32'd0 : bus_rdata;
               state_d = RESP;
            end else if (cnt_q == CNT_LAST) begin
               res_d   = 32'd0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
            if (who_q == REQ_DBG) begin
               ddone_d  = 1'b1;
               drdata_d = res_q;
            end else begin
               pdone_d  = 1'b1;
               prdata_d = res_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= 8'd0;
         we_q     <= 1'b0;
         sel_q    <= '0;
         wdata_q  <= 32'd0;
         who_q    <= REQ_PIPE;
         res_q    <= 32'd0;
         pdone_q  <= 1'b0;
         ddone_q  <= 1'b0;
         prdata_q <= 32'd0;
         drdata_q <= 32'd0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         we_q     <= we_d;
         sel_q    <= sel_d;
         wdata_q  <= wdata_d;
         who_q    <= who_d;
         res_q    <= res_d;
         pdone_q  <= pdone_d;
         ddone_q  <= ddone_d;
         prdata_q <= prdata_d;
         drdata_q <= drdata_d;
         err_q    <= err_d;
      end
   end

   assign bus_req    = (state_q == BUS);
   assign bus_we     = we_q;
   assign bus_sel    = sel_q;
   assign bus_wdata  = wdata_q;
   assign pipe_done  = pdone_q;
   assign pipe_rdata = prdata_q;
   assign pipe_stall = pipe_req & ~pdone_q;
   assign dbg_done   = ddone_q;
   assign dbg_rdata  = drdata_q;
   assign err        = err_q;

endmodule
